// File: rtl/psx_pkg.sv
// Shared definitions for the PSX pad frame assembler: FSM states, frame
// header constants and the bit position of each button in the 16-bit vector.
package psx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
  localparam logic [7:0] PSX_ID_ANALOG  = 8'h73;
  localparam logic [7:0] PSX_HDR_5A     = 8'h5A;
  localparam logic [7:0] STICK_CENTRE   = 8'h80;

  localparam int unsigned BTN_SELECT   = 0;
  localparam int unsigned BTN_L3       = 1;
  localparam int unsigned BTN_R3       = 2;
  localparam int unsigned BTN_START    = 3;
  localparam int unsigned BTN_UP       = 4;
  localparam int unsigned BTN_RIGHT    = 5;
  localparam int unsigned BTN_DOWN     = 6;
  localparam int unsigned BTN_LEFT     = 7;
  localparam int unsigned BTN_L2       = 8;
  localparam int unsigned BTN_R2       = 9;
  localparam int unsigned BTN_L1       = 10;
  localparam int unsigned BTN_R1       = 11;
  localparam int unsigned BTN_TRIANGLE = 12;
  localparam int unsigned BTN_CIRCLE   = 13;
  localparam int unsigned BTN_CROSS    = 14;
  localparam int unsigned BTN_SQUARE   = 15;

endpackage

// File: rtl/psx_frame_assembler_if.sv
// Read link between the frame assembler (master, drives the read address and
// burst-done flag) and the controller module (slave, holds the response bytes).
interface psx_frame_assembler_if;

  logic       data_ready;
  logic [7:0] controller_byte;
  logic [3:0] byte_address;
  logic       read_done;

  modport master (
    input  data_ready,
    input  controller_byte,
    output byte_address,
    output read_done
  );

  modport slave (
    output data_ready,
    output controller_byte,
    input  byte_address,
    input  read_done
  );

endinterface

// File: rtl/psx_sync2.sv
// Two-flop synchroniser bringing the controller's DataReady level into pclk.
module psx_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous level through two flops to settle metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/psx_frame_assembler.sv
// Burst-reads a pad response from the controller module, validates the header
// and publishes buttons, press/release pulses, sticks and link status.
module psx_frame_assembler
  import psx_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = 8,
  parameter logic [7:0]  ID_DIGITAL  = PSX_ID_DIGITAL,
  parameter logic [7:0]  ID_ANALOG   = PSX_ID_ANALOG,
  parameter logic [23:0] TIMEOUT     = 24'd3_000_000,
  parameter int unsigned ERR_W       = 8
) (
  input  logic                  pclk,
  input  logic                  rst,
  psx_frame_assembler_if.master link,
  output logic [15:0]           buttons,
  output logic [15:0]           pressed,
  output logic [15:0]           released,
  output logic [7:0]            stick_rx,
  output logic [7:0]            stick_ry,
  output logic [7:0]            stick_lx,
  output logic [7:0]            stick_ly,
  output logic                  analog_mode,
  output logic                  connected,
  output logic                  frame_err,
  output logic [ERR_W-1:0]      err_count
);

  localparam int unsigned       WD_W     = $clog2(int'(TIMEOUT) + 1);
  localparam int unsigned       CNT_W    = $clog2(FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_BYTES);
  localparam logic [3:0]        ADDR_LAST = 4'(FRAME_BYTES - 1);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(int'(TIMEOUT) - 1);

  logic dr_s;

  state_e            state_q, state_d;
  logic [3:0]        addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              read_done_q, read_done_d;
  logic [7:0]        shadow_q [FRAME_BYTES];
  logic [7:0]        shadow_d [FRAME_BYTES];
  logic [15:0]       buttons_q, buttons_d;
  logic [15:0]       pressed_q, pressed_d;
  logic [15:0]       released_q, released_d;
  logic [7:0]        rx_q, rx_d, ry_q, ry_d, lx_q, lx_d, ly_q, ly_d;
  logic              analog_q, analog_d;
  logic              connected_q, connected_d;
  logic              frame_err_q, frame_err_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              frame_ok;
  logic [15:0]       new_buttons;

  psx_sync2 u_sync (
    .clk_i  (pclk),
    .rst_ni (rst),
    .d_i    (link.data_ready),
    .q_o    (dr_s)
  );

  // State, shadow bytes and every published output live in these flops.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      read_done_q <= 1'b0;
      shadow_q    <= '{default: 8'h00};
      buttons_q   <= '0;
      pressed_q   <= '0;
      released_q  <= '0;
      rx_q        <= STICK_CENTRE;
      ry_q        <= STICK_CENTRE;
      lx_q        <= STICK_CENTRE;
      ly_q        <= STICK_CENTRE;
      analog_q    <= 1'b0;
      connected_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_q       <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      read_done_q <= read_done_d;
      shadow_q    <= shadow_d;
      buttons_q   <= buttons_d;
      pressed_q   <= pressed_d;
      released_q  <= released_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      lx_q        <= lx_d;
      ly_q        <= ly_d;
      analog_q    <= analog_d;
      connected_q <= connected_d;
      frame_err_q <= frame_err_d;
      err_q       <= err_d;
      wd_q        <= wd_d;
    end
  end

  // Next state: watchdog first, then the burst FSM whose valid commit overrides a coincident timeout.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    read_done_d = read_done_q;
    shadow_d    = shadow_q;
    buttons_d   = buttons_q;
    pressed_d   = '0;
    released_d  = '0;
    rx_d        = rx_q;
    ry_d        = ry_q;
    lx_d        = lx_q;
    ly_d        = ly_q;
    analog_d    = analog_q;
    connected_d = connected_q;
    frame_err_d = 1'b0;
    err_d       = err_q;
    wd_d        = wd_q;
    frame_ok    = ((shadow_q[0] == ID_DIGITAL) || (shadow_q[0] == ID_ANALOG)) &&
                  (shadow_q[1] == PSX_HDR_5A);
    new_buttons = ~{shadow_q[3], shadow_q[2]};

    if (connected_q) begin
      wd_d = wd_q + 1'b1;
      if (wd_q == WD_LAST) begin
        connected_d = 1'b0;
        buttons_d   = '0;
        released_d  = buttons_q;
        rx_d        = STICK_CENTRE;
        ry_d        = STICK_CENTRE;
        lx_d        = STICK_CENTRE;
        ly_d        = STICK_CENTRE;
        analog_d    = 1'b0;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (dr_s && !read_done_q) begin
          state_d = FETCH;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end
      FETCH: begin
        for (int i = 0; i < int'(FRAME_BYTES); i++) begin
          if (cnt_q == CNT_W'(i + 1)) shadow_d[i] = link.controller_byte;
        end
        if (cnt_q == CNT_LAST) state_d = CHECK;
        else cnt_d = cnt_q + 1'b1;
        if (addr_q != ADDR_LAST) addr_d = addr_q + 1'b1;
      end
      CHECK: begin
        state_d     = DONE;
        read_done_d = 1'b1;
        if (frame_ok) begin
          buttons_d   = new_buttons;
          pressed_d   = new_buttons & ~buttons_q;
          released_d  = ~new_buttons & buttons_q;
          wd_d        = '0;
          connected_d = 1'b1;
          if (shadow_q[0] == ID_ANALOG) begin
            rx_d     = shadow_q[4];
            ry_d     = shadow_q[5];
            lx_d     = shadow_q[6];
            ly_d     = shadow_q[7];
            analog_d = 1'b1;
          end else begin
            rx_d     = STICK_CENTRE;
            ry_d     = STICK_CENTRE;
            lx_d     = STICK_CENTRE;
            ly_d     = STICK_CENTRE;
            analog_d = 1'b0;
          end
        end else begin
          frame_err_d = 1'b1;
          if (err_q != '1) err_d = err_q + 1'b1;
        end
      end
      DONE: begin
        if (!dr_s) begin
          read_done_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign link.byte_address = addr_q;
  assign link.read_done    = read_done_q;
  assign buttons           = buttons_q;
  assign pressed           = pressed_q;
  assign released          = released_q;
  assign stick_rx          = rx_q;
  assign stick_ry          = ry_q;
  assign stick_lx          = lx_q;
  assign stick_ly          = ly_q;
  assign analog_mode       = analog_q;
  assign connected         = connected_q;
  assign frame_err         = frame_err_q;
  assign err_count         = err_q;

endmodule

// File: tb/tb_psx_frame_assembler.sv
// Scoreboard bench for psx_frame_assembler: each driven frame pushes its
// expected commit result, popped when read_done rises.
module tb_psx_frame_assembler;
  import psx_pkg::*;

  localparam int unsigned TB_TIMEOUT = 100;

  logic        pclk;
  logic        rst;
  logic [15:0] buttons, pressed, released;
  logic [7:0]  stick_rx, stick_ry, stick_lx, stick_ly;
  logic        analog_mode, connected, frame_err;
  logic [7:0]  err_count;

  psx_frame_assembler_if link ();

  psx_frame_assembler #(
    .FRAME_BYTES (8),
    .ID_DIGITAL  (8'h41),
    .ID_ANALOG   (8'h73),
    .TIMEOUT     (24'(TB_TIMEOUT)),
    .ERR_W       (8)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .link        (link.master),
    .buttons     (buttons),
    .pressed     (pressed),
    .released    (released),
    .stick_rx    (stick_rx),
    .stick_ry    (stick_ry),
    .stick_lx    (stick_lx),
    .stick_ly    (stick_ly),
    .analog_mode (analog_mode),
    .connected   (connected),
    .frame_err   (frame_err),
    .err_count   (err_count)
  );

  typedef struct {
    logic        fe;
    logic [15:0] btn, prs, rel;
    logic [7:0]  rx, ry, lx, ly;
    logic        an, conn;
    logic [7:0]  err;
  } exp_t;

  exp_t        sbQ[$];
  logic [7:0]  mem [8];
  logic [3:0]  lastAddr;
  int          checks, errors;
  int          cyc, commitCyc;
  logic [15:0] mBtn;
  logic [7:0]  mRx, mRy, mLx, mLy, mErr;
  logic        mAn, mConn;

  // 10 ns pclk
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // cycle counter used to time the watchdog
  initial begin
    cyc = 0;
    forever begin
      @(posedge pclk);
      cyc++;
    end
  end

  // controller module model: registered read, byte for the previous address
  initial begin
    lastAddr = '0;
    link.controller_byte = 8'h00;
    forever begin
      @(negedge pclk);
      link.controller_byte = mem[lastAddr[2:0]];
      lastAddr = link.byte_address;
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL global_timeout: got stuck, expected finish");
    $fatal(1, "[TB] simulation hung");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic resetModel();
    mBtn = '0; mRx = 8'h80; mRy = 8'h80; mLx = 8'h80; mLy = 8'h80;
    mAn = 1'b0; mConn = 1'b0; mErr = 8'h00;
  endtask

  task automatic pushFrame(input logic [63:0] frame);
    exp_t e;
    logic [7:0] b [8];
    logic [15:0] nb;
    for (int i = 0; i < 8; i++) b[i] = frame[63-8*i -: 8];
    e.prs = '0; e.rel = '0; e.fe = 1'b0;
    if ((b[0] == 8'h41 || b[0] == 8'h73) && b[1] == 8'h5A) begin
      nb = ~{b[3], b[2]};
      e.prs = nb & ~mBtn;
      e.rel = ~nb & mBtn;
      mBtn = nb;
      mConn = 1'b1;
      if (b[0] == 8'h73) begin
        mRx = b[4]; mRy = b[5]; mLx = b[6]; mLy = b[7]; mAn = 1'b1;
      end else begin
        mRx = 8'h80; mRy = 8'h80; mLx = 8'h80; mLy = 8'h80; mAn = 1'b0;
      end
    end else begin
      e.fe = 1'b1;
      if (mErr != 8'hFF) mErr = mErr + 8'd1;
    end
    e.btn = mBtn; e.rx = mRx; e.ry = mRy; e.lx = mLx; e.ly = mLy;
    e.an = mAn; e.conn = mConn; e.err = mErr;
    sbQ.push_back(e);
  endtask

  // mode 0: normal burst, 1: drop data_ready mid-FETCH, 2: reset mid-FETCH
  task automatic applyStimulus(input logic [63:0] frame, input int mode);
    logic [3:0] addrs[$];
    int last0, sweepLen;
    bit didReset;
    for (int i = 0; i < 8; i++) mem[i] = frame[63-8*i -: 8];
    pushFrame(frame);
    didReset = 1'b0;
    addrs.push_back(link.byte_address);
    link.data_ready = 1'b1;
    for (int c = 0; c < 60 && !link.read_done; c++) begin
      @(negedge pclk);
      if (link.byte_address != addrs[$]) addrs.push_back(link.byte_address);
      if (mode == 1 && link.byte_address == 4'd3) link.data_ready = 1'b0;
      if (mode == 2 && link.byte_address == 4'd4 && !didReset) begin
        didReset = 1'b1;
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_buttons", buttons, 16'h0);
        checkOutput("rst_pressed", pressed, 16'h0);
        checkOutput("rst_connected", connected, 0);
        checkOutput("rst_addr", link.byte_address, 0);
        checkOutput("rst_read_done", link.read_done, 0);
        checkOutput("rst_sticks", {stick_rx, stick_ry, stick_lx, stick_ly}, 32'h80808080);
        checkOutput("rst_analog", analog_mode, 0);
        checkOutput("rst_err_count", err_count, 0);
        resetModel();
        sbQ.delete();
        pushFrame(frame);
        @(negedge pclk);
        @(negedge pclk);
        rst = 1'b1;
        addrs.delete();
        addrs.push_back(link.byte_address);
      end
    end
    checkOutput("rd_rise", link.read_done, 1);
    last0 = -1;
    for (int i = 0; i < addrs.size(); i++) if (addrs[i] == 4'd0) last0 = i;
    sweepLen = 0;
    if (last0 >= 0) begin
      for (int i = last0; i < addrs.size(); i++) if (int'(addrs[i]) == i - last0) sweepLen++;
      if (addrs.size() - last0 != 8) sweepLen = 99;
    end
    checkOutput("addr_sweep", sweepLen, 8);
    if (mode == 1) begin
      @(negedge pclk);
      checkOutput("rd_one_cycle", link.read_done, 0);
    end else begin
      repeat (3) @(negedge pclk);
      checkOutput("rd_hold", link.read_done, 1);
      link.data_ready = 1'b0;
      for (int c = 0; c < 8 && link.read_done; c++) @(negedge pclk);
      checkOutput("rd_fall", link.read_done, 0);
    end
  endtask

  // scoreboard monitor: compare on each read_done rise, pulses clear a cycle later
  initial begin
    exp_t e;
    logic prevRd;
    bit chkNext;
    prevRd = 1'b0;
    chkNext = 1'b0;
    forever begin
      @(negedge pclk);
      if (chkNext) begin
        checkOutput("pressed_clr", pressed, 0);
        checkOutput("released_clr", released, 0);
        checkOutput("frame_err_clr", frame_err, 0);
        chkNext = 1'b0;
      end
      if (rst && link.read_done && !prevRd) begin
        if (sbQ.size() == 0) begin
          checkOutput("sb_underflow", sbQ.size(), 1);
        end else begin
          e = sbQ.pop_front();
          checkOutput("frame_err", frame_err, e.fe);
          checkOutput("buttons", buttons, e.btn);
          checkOutput("pressed", pressed, e.prs);
          checkOutput("released", released, e.rel);
          checkOutput("sticks", {stick_rx, stick_ry, stick_lx, stick_ly}, {e.rx, e.ry, e.lx, e.ly});
          checkOutput("analog_mode", analog_mode, e.an);
          checkOutput("connected", connected, e.conn);
          checkOutput("err_count", err_count, e.err);
          commitCyc = cyc;
          chkNext = 1'b1;
        end
      end
      prevRd = link.read_done;
    end
  end

  initial begin
    logic [63:0] bad;
    checks = 0;
    errors = 0;
    commitCyc = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    resetModel();
    rst = 1'b0;
    link.data_ready = 1'b0;
    repeat (3) @(negedge pclk);
    checkOutput("reset_buttons", buttons, 16'h0);
    checkOutput("reset_sticks", {stick_rx, stick_ry, stick_lx, stick_ly}, 32'h80808080);
    checkOutput("reset_connected", connected, 0);
    rst = 1'b1;
    repeat (2) @(negedge pclk);

    $display("[TB] digital frame");
    applyStimulus({8'h41, 8'h5A, 8'hFE, 8'hFF, 32'h0}, 0);
    checkOutput("digital_select", buttons[BTN_SELECT], 1);

    $display("[TB] analog frame");
    applyStimulus({8'h73, 8'h5A, 8'hFF, 8'hBF, 8'h10, 8'h20, 8'h30, 8'h40}, 0);
    checkOutput("analog_cross", buttons[BTN_CROSS], 1);

    $display("[TB] bad header");
    applyStimulus({8'h41, 8'h00, 8'hFE, 8'hFF, 32'h0}, 0);

    $display("[TB] analog release");
    applyStimulus({8'h73, 8'h5A, 8'hFF, 8'hFF, 8'h10, 8'h20, 8'h30, 8'h40}, 0);

    $display("[TB] watchdog");
    applyStimulus({8'h73, 8'h5A, 8'h7E, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44}, 0);
    while (cyc < commitCyc + int'(TB_TIMEOUT) - 1) @(negedge pclk);
    checkOutput("wd_before_conn", connected, 1);
    checkOutput("wd_before_btn", buttons, 16'h0081);
    @(negedge pclk);
    checkOutput("wd_conn", connected, 0);
    checkOutput("wd_buttons", buttons, 16'h0);
    checkOutput("wd_released", released, 16'h0081);
    checkOutput("wd_sticks", {stick_rx, stick_ry, stick_lx, stick_ly}, 32'h80808080);
    checkOutput("wd_analog", analog_mode, 0);
    @(negedge pclk);
    checkOutput("wd_released_clr", released, 16'h0);
    mBtn = '0; mRx = 8'h80; mRy = 8'h80; mLx = 8'h80; mLy = 8'h80; mAn = 1'b0; mConn = 1'b0;

    $display("[TB] error counter saturation");
    for (int n = 0; n < 300; n++) begin
      bad = {8'h41, 8'h00, 48'($urandom) ^ (48'($urandom) << 16)};
      if (n % 2 == 1) bad[63:48] = {8'h55, 8'h5A};
      applyStimulus(bad, 0);
    end
    checkOutput("err_saturated", err_count, 8'hFF);

    $display("[TB] drop data_ready mid-fetch");
    applyStimulus({8'h41, 8'h5A, 8'hFF, 8'hFE, 32'h0}, 1);
    checkOutput("drop_l2", buttons[BTN_L2], 1);
    repeat (2) @(negedge pclk);

    $display("[TB] reset mid-fetch");
    applyStimulus({8'h41, 8'h5A, 8'hFE, 8'hFE, 32'h0}, 2);
    repeat (3) @(negedge pclk);
    checkOutput("sb_drain", sbQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psx_frame_assembler.md
Name: psx_frame_assembler

Overview:
- Sits downstream of psx_controller_module, on the player-input side, in the pclk domain.
- When the controller module flags DataReady, it burst-reads the received response bytes over the ByteAddress/ControllerByte port and validates the frame header.
- It publishes a stable active-high button vector, one-cycle press/release pulses and analog stick values to the game logic.
- A link watchdog clears all inputs when the pad stops answering.

Parameters:
- FRAME_BYTES, 8, bytes fetched per burst (addr 0 = ID, 1 = 0x5A, 2-3 = buttons, 4-7 = RX, RY, LX, LY).
- ID_DIGITAL, 8'h41, ID byte for a digital pad.
- ID_ANALOG, 8'h73, ID byte for an analog pad.
- TIMEOUT, 24'd3_000_000, pclk cycles without a valid frame before connected drops.
- ERR_W, 8, width of the frame error counter.

Ports:
- pclk  in  1  block clock.
- rst  in  1  reset, asynchronous, active-low.
- data_ready  in  1  DataReady from the controller module; asynchronous to pclk, level, high while a frame is held.
- controller_byte  in  8  byte at byte_address.
- byte_address  out  4  read address to the controller module.
- read_done  out  1  burst finished; drives the controller module's read_burst input.
- buttons  out  16  button state, active-high: bit 0 = byte2 bit 0 … bit 15 = byte3 bit 7.
- pressed  out  16  1-cycle pulse per button, 0→1.
- released  out  16  1-cycle pulse per button, 1→0.
- stick_rx, stick_ry, stick_lx, stick_ly  out  8 each  analog values; 8'h80 when not in analog mode.
- analog_mode  out  1  last valid frame had ID_ANALOG.
- connected  out  1  a valid frame was seen within TIMEOUT.
- frame_err  out  1  1-cycle pulse on a rejected frame.
- err_count  out  ERR_W  rejected-frame count, saturating.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; byte_address 0; read_done 0; buttons, pressed, released 0; sticks 8'h80; analog_mode 0; connected 0; frame_err 0; err_count 0; watchdog 0; shadow bytes 0.
- data_ready passes through a 2-flop synchroniser (dr_s). Only dr_s is used internally.
- FSM:
  - IDLE: on dr_s=1 and read_done=0, go to FETCH with byte_address=0.
  - FETCH: controller_byte is registered one pclk after byte_address changes. The block drives address k in cycle k and captures byte k-1 in the same cycle. byte_address increments to FRAME_BYTES-1, then holds. The last byte is captured one cycle later, so FETCH lasts FRAME_BYTES+1 cycles, then go to CHECK.
  - CHECK (1 cycle):
    - Valid = (byte0==ID_DIGITAL or byte0==ID_ANALOG) and byte1==8'h5A.
    - If valid: new_buttons = ~{byte3, byte2}; pressed = new & ~buttons; released = ~new & buttons; buttons <= new.
    - If byte0==ID_ANALOG: sticks <= bytes4-7 and analog_mode <= 1. Otherwise sticks <= 8'h80 and analog_mode <= 0.
    - Watchdog clears; connected <= 1.
    - If invalid: outputs hold, frame_err pulses, err_count increments and saturates at all-ones.
    - Go to DONE.
  - DONE: read_done=1. Stay until dr_s=0, then read_done=0 and go to IDLE.
- Latency: first dr_s=1 cycle to buttons update is FRAME_BYTES+2 pclk. Total from data_ready rise is that plus 2 synchroniser cycles.
- pressed and released are 0 in every cycle except the CHECK-commit cycle.
- If dr_s falls during FETCH or CHECK, the burst is completed and committed anyway; DONE then exits on the next cycle.
- Watchdog increments every pclk while connected=1 and saturates at TIMEOUT. On reaching TIMEOUT: connected <= 0; buttons <= 0 and released pulses for the set bits; sticks 8'h80; analog_mode 0.
- A valid commit in the same cycle as the timeout wins: connected stays 1 and the watchdog clears.
- All comparisons are 8-bit exact. The watchdog width is ceil(log2(TIMEOUT+1)).

Decomposition:
- Package psx_pkg holds:
  - state encoding IDLE/FETCH/CHECK/DONE;
  - PSX_ID_DIGITAL, PSX_ID_ANALOG, PSX_HDR_5A, STICK_CENTRE=8'h80;
  - button bit indices (SELECT=0, L3, R3, START, UP, RIGHT, DOWN, LEFT, L2, R2, L1, R1, TRIANGLE, CIRCLE, CROSS, SQUARE=15).
- One sub-module: psx_sync2, the 2-flop synchroniser with async active-low reset.

Test Plan:
- Digital frame {41,5A,FE,FF,…}: after data_ready rises → byte_address sweeps 0..7; buttons=16'h0001; pressed=16'h0001 for 1 cycle; analog_mode=0; read_done=1 until data_ready falls.
- Analog frame {73,5A,FF,BF,10,20,30,40}: stick_rx=10, stick_ry=20, stick_lx=30, stick_ly=40; buttons=16'h4000; analog_mode=1. Then the same frame with byte3=FF → released=16'h4000 pulse, buttons=0.
- Bad header {41,00,…}: frame_err pulses once; err_count 0→1; buttons unchanged; connected unchanged. Run 300 bad frames with ERR_W=8 → err_count=255.
- TIMEOUT=100, valid frame with buttons=16'h0081, then silence → connected=0 and buttons=0 exactly 100 cycles after commit; released=16'h0081 pulse; sticks=80.
- Drop data_ready mid-FETCH → frame still committed; read_done high exactly 1 cycle, then IDLE.
- Assert rst mid-FETCH → all outputs immediately at reset values. After release with data_ready still high → a fresh burst starts from address 0.
